// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq -- iterative shift-add unsigned multiplier
//
// Forms a 2N-bit product of two N-bit unsigned operands. It uses one
// conditional add and one shift per cycle. The low half of the product
// drives one input of the ALU result selector. The high half is exposed for
// long-multiply use. A start/busy/done handshake lets the control unit stall
// while the multiply runs.
//
// Parameters
//   N          operand width (product is 2N bits), default 32
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset, priority over start
//   start      in   1  request a multiply, accepted only while busy = 0
//   a          in   N  multiplicand, sampled on the accepting edge only
//   b          in   N  multiplier, sampled on the accepting edge only
//   result     out  N  low half of the last completed product
//   result_hi  out  N  high half of the last completed product
//   busy       out  1  high while iterating (state RUN)
//   done       out  1  one-cycle pulse when result/result_hi were just updated
//
// Build option
//   MULT_EARLY_TERM_EN  when defined, the iteration that shifts the last set
//                       multiplier bit out is treated as final. The product is
//                       unchanged and the latency follows the top set bit of b.
//                       When undefined, every multiply takes exactly N iterations.
// ---------------------------------------------------------------------------
module mult_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         busy,
   output logic         done
);

   // Counter holds completed iterations. One spare bit guarantees that it
   // never wraps within an operation.
   localparam int            CW       = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;

   logic [2*N-1:0]   mcand_r;
   logic [2*N-1:0]   acc_r;
   logic [N-1:0]     mplier_r;
   logic [CW-1:0]    cnt_r;

   logic [N-1:0]     result_r;
   logic [N-1:0]     result_hi_r;
   logic             busy_r;
   logic             done_r;

   logic [2*N-1:0]   addend_s;
   logic [2*N-1:0]   acc_sum_s;
   logic [N-1:0]     mplier_shift_s;
   logic             last_s;
   logic             load_s;
   logic             iter_s;
   logic             final_s;

   // Partial product of this iteration and the shifted multiplier.
   always_comb begin
      addend_s = {(2*N){1'b0}};
      if (mplier_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = {(2*N){1'b0}};
      end
      // Both addends fit in 2N bits and their sum never exceeds a*b, so this add cannot overflow.
      acc_sum_s      = acc_r + addend_s;
      mplier_shift_s = mplier_r >> 1;
   end

`ifdef MULT_EARLY_TERM_EN
   // The iteration is final once no set multiplier bit remains after this shift.
   // The count limit is kept as a backstop.
   assign last_s = (cnt_r == CNT_LAST) || (mplier_shift_s == {N{1'b0}});
`else
   // The N-th iteration (counter at N-1 before it) is always the last one.
   assign last_s = (cnt_r == CNT_LAST);
`endif

   // Next-state and datapath control decode.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      iter_s  = 1'b0;
      final_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: requests while busy are dropped.
            iter_s = 1'b1;
            if (last_s) begin
               state_s = DONE;
               final_s = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            // A start in the done cycle is accepted and goes straight to RUN.
            if (start) begin
               state_s = RUN;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register plus registered busy/done flags, which are derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == RUN);
         done_r  <= (state_s == DONE);
      end
   end

   // Operand, accumulator and iteration-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_r  <= {(2*N){1'b0}};
         mplier_r <= {N{1'b0}};
         acc_r    <= {(2*N){1'b0}};
         cnt_r    <= CNT_ZERO;
      end else if (load_s) begin
         mcand_r  <= {{N{1'b0}}, a};
         mplier_r <= b;
         acc_r    <= {(2*N){1'b0}};
         cnt_r    <= CNT_ZERO;
      end else if (iter_s) begin
         acc_r    <= acc_sum_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_shift_s;
         cnt_r    <= cnt_r + CNT_ONE;
      end else begin
         mcand_r  <= mcand_r;
         mplier_r <= mplier_r;
         acc_r    <= acc_r;
         cnt_r    <= cnt_r;
      end
   end

   // Product registers. They load only on the edge into DONE and hold through IDLE and any later RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r    <= {N{1'b0}};
         result_hi_r <= {N{1'b0}};
      end else if (final_s) begin
         // The last iteration's own add is included.
         result_r    <= acc_sum_s[N-1:0];
         result_hi_r <= acc_sum_s[2*N-1:N];
      end else begin
         result_r    <= result_r;
         result_hi_r <= result_hi_r;
      end
   end

   assign result    = result_r;
   assign result_hi = result_hi_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_seq -- directed self-checking bench for mult_seq (N = 32)
//
// Inputs are driven and outputs are sampled on the falling edge.
// "edges" counts rising edges after the accepting edge k, up to the first
// cycle in which done is high (N without early termination).
// ---------------------------------------------------------------------------
module tb_mult_seq;

   localparam int N = 32;

`ifdef MULT_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   // Delays are shortened with early termination so that the events still land inside RUN.
   localparam int IGN_DLY = ET ? 2 : 4;
   localparam int RST_DLY = ET ? 2 : 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] result;
   logic [N-1:0] result_hi;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mult_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .result    (result),
      .result_hi (result_hi),
      .busy      (busy),
      .done      (done)
   );

   // Expected edge count from the accepting edge to the first done cycle.
   function automatic int exp_edges(input logic [N-1:0] bv);
      int m;
      m = -1;
      for (int i = 0; i < N; i++) begin
         if (bv[i]) m = i;
      end
      return ET ? ((m < 0) ? 1 : m + 1) : N;
   endfunction

   // Called on a falling edge: request a multiply, let one rising edge accept it,
   // then scramble the operands.
   task automatic issue_now(input logic [N-1:0] av, input logic [N-1:0] bv);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1234_5678;
   endtask

   task automatic issue_start(input logic [N-1:0] av, input logic [N-1:0] bv);
      @(negedge clk);
      issue_now(av, bv);
   endtask

   // Wait (bounded) for done; returns the edges taken and the busy cycles seen.
   task automatic wait_done(output int edges, output int busy_cyc, output bit to);
      edges    = 0;
      busy_cyc = busy ? 1 : 0;
      to       = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (done) begin
            to = 1'b0;
            break;
         end
         if (busy) busy_cyc++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      n_checks++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL reset_result_hi: got %h expected 0", result_hi); end
   endtask

   task automatic test_basic();
      int e, bc; bit to;
      issue_start(32'd7, 32'd6);
      wait_done(e, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
      n_checks++; if (e !== exp_edges(32'd6)) begin n_fail++; $display("FAIL basic_latency: got %0d edges expected %0d", e, exp_edges(32'd6)); end
      n_checks++; if (bc !== exp_edges(32'd6)) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, exp_edges(32'd6)); end
      n_checks++; if (result !== 32'd42) begin n_fail++; $display("FAIL basic_result: got %0d expected 42", result); end
      n_checks++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL basic_result_hi: got %h expected 0", result_hi); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
      n_checks++; if (result !== 32'd42) begin n_fail++; $display("FAIL basic_hold: got %0d expected 42", result); end
   endtask

   task automatic test_max();
      int e, bc; bit to;
      issue_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(e, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL max_timeout: got no done expected done"); end
      n_checks++; if (e !== N) begin n_fail++; $display("FAIL max_latency: got %0d edges expected %0d", e, N); end
      n_checks++; if (result !== 32'h0000_0001) begin n_fail++; $display("FAIL max_result: got %h expected 00000001", result); end
      n_checks++; if (result_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL max_result_hi: got %h expected fffffffe", result_hi); end
   endtask

   task automatic test_ignore_start();
      int e, bc, extra; bit to;
      issue_start(32'd3, 32'd5);
      repeat (IGN_DLY - 1) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b expected 1", busy); end
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      wait_done(e, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL ignore_timeout: got no done expected done"); end
      n_checks++; if (e !== exp_edges(32'd5) - IGN_DLY) begin n_fail++; $display("FAIL ignore_latency: got %0d edges expected %0d", e, exp_edges(32'd5) - IGN_DLY); end
      n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL ignore_result: got %0d expected 15", result); end
      extra = 0;
      for (int i = 0; i < N + 5; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_activity: got %0d cycles expected 0", extra); end
   endtask

   task automatic test_back_to_back();
      int e, bc, bad; bit to;
      issue_start(32'd2, 32'd3);
      wait_done(e, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout: got no done expected done"); end
      n_checks++; if (result !== 32'd6) begin n_fail++; $display("FAIL b2b_first_result: got %0d expected 6", result); end
      issue_now(32'd4, 32'd4);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
      e   = 0;
      bad = 0;
      to  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (result !== 32'd6) bad++;
         @(posedge clk);
         @(negedge clk);
         e++;
         if (done) begin
            to = 1'b0;
            break;
         end
      end
      n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout: got no done expected done"); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_result_hold: got %0d changed cycles expected 0", bad); end
      n_checks++; if (e !== exp_edges(32'd4)) begin n_fail++; $display("FAIL b2b_latency: got %0d edges expected %0d", e, exp_edges(32'd4)); end
      n_checks++; if (result !== 32'd16) begin n_fail++; $display("FAIL b2b_second_result: got %0d expected 16", result); end
   endtask

   task automatic test_mid_reset();
      int e, bc, dones; bit to;
      issue_start(32'd5, 32'd5);
      repeat (RST_DLY - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result); end
      n_checks++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL midrst_result_hi: got %h expected 0", result_hi); end
      dones = 0;
      for (int i = 0; i < N + 5; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dones); end
      issue_start(32'd2, 32'd2);
      wait_done(e, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL midrst_fresh_timeout: got no done expected done"); end
      n_checks++; if (result !== 32'd4) begin n_fail++; $display("FAIL midrst_fresh_result: got %0d expected 4", result); end
   endtask

`ifdef MULT_EARLY_TERM_EN
   task automatic test_early_term();
      int e, bc; bit to;
      issue_start(32'd100, 32'd0);
      wait_done(e, bc, to);
      n_checks++; if (to || e !== 1) begin n_fail++; $display("FAIL et_b0_latency: got %0d edges expected 1", e); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL et_b0_result: got %0d expected 0", result); end
      issue_start(32'd100, 32'd1);
      wait_done(e, bc, to);
      n_checks++; if (to || e !== 1) begin n_fail++; $display("FAIL et_b1_latency: got %0d edges expected 1", e); end
      n_checks++; if (result !== 32'd100) begin n_fail++; $display("FAIL et_b1_result: got %0d expected 100", result); end
      issue_start(32'd1, 32'h8000_0000);
      wait_done(e, bc, to);
      n_checks++; if (to || e !== 32) begin n_fail++; $display("FAIL et_top_latency: got %0d edges expected 32", e); end
      n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL et_top_result: got %h expected 80000000", result); end
      n_checks++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL et_top_result_hi: got %h expected 0", result_hi); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
`ifdef MULT_EARLY_TERM_EN
      test_early_term();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
